adc_tone_gen: RTL

Parametrised multi-channel digital test-tone source that stands in for the external ADC in the rxadc datapath. On each sample strobe it produces NCH independent signed samples (sine, square, sawtooth or DC) from per-channel phase accumulators. Frequency, phase offset, amplitude and waveform are register-programmable. It enables in-system loopback and self-test of the downsampler/PDM chain without an RF input.

---
 rtl/adc_tone_pkg.sv | 22 ++
 rtl/adc_tone_chan.sv | 124 ++++++++++++
 rtl/adc_tone_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/adc_tone_pkg.sv
// Shared constants for the test-tone generator: waveform modes, register map
// and the full-scale helper used by both the LUT builder and the channels.
package adc_tone_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_SQUARE = 2'd1,
      MODE_SAW    = 2'd2,
      MODE_DC     = 2'd3
   } mode_e;

   localparam logic [1:0] REG_FREQ = 2'd0;
   localparam logic [1:0] REG_POFS = 2'd1;
   localparam logic [1:0] REG_AMP  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // Largest symmetric positive code for a signed dw-bit sample.
   function automatic int fs_of(input int dw);
      return (1 << (dw - 1)) - 1;
   endfunction

endpackage

// File: rtl/adc_tone_chan.sv
// One tone channel: phase accumulator, waveform generation from a registered
// quarter-wave ROM, and amplitude scaling. Three register stages from ena to dout.
module adc_tone_chan
   import adc_tone_pkg::*;
#(
   parameter int DW     = 10,
   parameter int PW     = 26,
   parameter int LUT_AW = 8,
   parameter logic [(2**LUT_AW)*(DW-1)-1:0] LUT_INIT = '0
)(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 ena_i,
   input  logic                 sync_i,
   input  logic [PW-1:0]        freq_i,
   input  logic [PW-1:0]        pofs_i,
   input  logic [DW-2:0]        amp_i,
   input  mode_e                mode_i,
   output logic signed [DW-1:0] dout_o,
   output logic                 valid_o
);

   localparam int LW = DW - 1;
   localparam logic signed [DW-1:0] FS = DW'(fs_of(DW));

   // Saw: top DW phase bits with MSB flipped; the lone most-negative code is
   // pulled in to -FS so the ramp stays symmetric.
   function automatic logic signed [DW-1:0] saw_wave(input logic [PW-1:0] p);
      logic signed [DW-1:0] s;
      s = $signed({~p[PW-1], p[PW-2 -: DW-1]});
      if (s == {1'b1, {(DW-1){1'b0}}}) s = -FS;
      return s;
   endfunction

   // Amplitude scaling with floor (arithmetic shift); |wave| <= FS and
   // amp <= FS keep the result inside DW bits.
   function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] w,
                                                  input logic [DW-2:0] a);
      logic signed [2*DW-1:0] prod;
      prod = (2*DW)'(w) * (2*DW)'($signed({1'b0, a}));
      prod = prod >>> (DW - 1);
      return prod[DW-1:0];
   endfunction

   logic [PW-1:0]        acc_q, acc_d, phase_src;
   logic [PW-1:0]        phase_p1;
   mode_e                mode_p1, mode_p2;
   logic [DW-2:0]        amp_p1, amp_p2;
   logic [LUT_AW-1:0]    lut_idx;
   logic signed [DW-1:0] alt_wave, alt_p2, wave_p2;
   logic [LW-1:0]        lut_p2;
   logic                 neg_p2;
   logic                 vld_p1, vld_p2, vld_p3;
   logic signed [DW-1:0] dout_q;
   logic                 unused_phase;

   assign unused_phase = ^phase_p1;

   // Accumulator next state; sync zeroes it, and a coincident sample is taken
   // at phase zero with the accumulator advancing from there.
   always_comb begin
      acc_d     = acc_q;
      phase_src = acc_q;
      if (sync_i) begin
         phase_src = '0;
         acc_d     = ena_i ? freq_i : '0;
      end else if (ena_i) begin
         acc_d = acc_q + freq_i;
      end
   end

   // Quarter-wave index mirroring and non-sine waveforms from the S1 phase.
   always_comb begin
      lut_idx  = phase_p1[PW-3 -: LUT_AW] ^ {LUT_AW{phase_p1[PW-2]}};
      alt_wave = FS;
      case (mode_p1)
         MODE_SQUARE: alt_wave = phase_p1[PW-1] ? -FS : FS;
         MODE_SAW:    alt_wave = saw_wave(phase_p1);
         default:     alt_wave = FS;
      endcase
   end

   // Final waveform select with quadrant sign applied to the ROM magnitude.
   always_comb begin
      wave_p2 = alt_p2;
      if (mode_p2 == MODE_SINE)
         wave_p2 = neg_p2 ? -$signed({1'b0, lut_p2}) : $signed({1'b0, lut_p2});
   end

   // Control state: accumulator, valid pipeline and held output.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q  <= '0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         dout_q <= '0;
      end else begin
         acc_q  <= acc_d;
         vld_p1 <= ena_i;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         if (vld_p2) dout_q <= scale(wave_p2, amp_p2);
      end
   end

   // Data pipeline: S1 phase add, S2 ROM lookup / waveform register.
   always_ff @(posedge clk_i) begin
      // S1
      phase_p1 <= phase_src + pofs_i;
      mode_p1  <= mode_i;
      amp_p1   <= amp_i;
      // S2
      lut_p2   <= LUT_INIT[int'(lut_idx)*LW +: LW];
      neg_p2   <= phase_p1[PW-1];
      alt_p2   <= alt_wave;
      mode_p2  <= mode_p1;
      amp_p2   <= amp_p1;
   end

   assign dout_o  = dout_q;
   assign valid_o = vld_p3;

endmodule

// File: rtl/adc_tone_gen.sv
// Multi-channel test-tone source standing in for the ADC: register decode,
// sync fan-out and the elaboration-time quarter-wave sine table.
module adc_tone_gen
   import adc_tone_pkg::*;
#(
   parameter int DW     = 10,
   parameter int PW     = 26,
   parameter int NCH    = 2,
   parameter int LUT_AW = 8
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ena,
   input  logic                       cfg_we,
   input  logic [$clog2(NCH)+1:0]     cfg_addr,
   input  logic [31:0]                cfg_wdata,
   input  logic                       sync,
   output logic [NCH*DW-1:0]          dout,
   output logic                       valid
);

   localparam int AW = $clog2(NCH) + 2;
   localparam int LW = DW - 1;
   localparam int LN = 2**LUT_AW;

   // Quarter-wave table sampled at bin centres, rounded to nearest.
   function automatic logic [LN*LW-1:0] gen_lut();
      logic [LN*LW-1:0] t;
      real              x;
      int               v;
      t = '0;
      for (int i = 0; i < LN; i++) begin
         x = real'(fs_of(DW)) *
             $sin(3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(LN));
         v = $rtoi(x + 0.5);
         t[i*LW +: LW] = LW'(v);
      end
      return t;
   endfunction

   localparam logic [LN*LW-1:0] LUT_INIT = gen_lut();

   logic [PW-1:0] freq_q [NCH];
   logic [PW-1:0] pofs_q [NCH];
   logic [DW-2:0] amp_q  [NCH];
   mode_e         mode_q [NCH];
   logic          ctrl_sync_q;
   logic          sync_all;
   logic [1:0]    reg_sel;
   logic [AW-1:0] chan_sel;
   logic [NCH-1:0] chan_vld;
   logic          unused_wdata;

   assign reg_sel      = cfg_addr[1:0];
   assign chan_sel     = cfg_addr >> 2;
   assign sync_all     = sync | ctrl_sync_q;
   assign unused_wdata = ^cfg_wdata;

   // Register file; CTRL sync is registered so it lands with the next sample
   // like every other write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            freq_q[c] <= '0;
            pofs_q[c] <= '0;
            amp_q[c]  <= '0;
            mode_q[c] <= MODE_SINE;
         end
         ctrl_sync_q <= 1'b0;
      end else begin
         ctrl_sync_q <= cfg_we && (reg_sel == REG_CTRL) && (chan_sel == '0) && cfg_wdata[0];
         if (cfg_we) begin
            for (int c = 0; c < NCH; c++) begin
               if (chan_sel == AW'(c)) begin
                  case (reg_sel)
                     REG_FREQ: freq_q[c] <= cfg_wdata[PW-1:0];
                     REG_POFS: pofs_q[c] <= cfg_wdata[PW-1:0];
                     REG_AMP: begin
                        amp_q[c]  <= cfg_wdata[DW-2:0];
                        mode_q[c] <= mode_e'(cfg_wdata[17:16]);
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      adc_tone_chan #(
         .DW       (DW),
         .PW       (PW),
         .LUT_AW   (LUT_AW),
         .LUT_INIT (LUT_INIT)
      ) u_chan (
         .clk_i   (clk),
         .reset_i (reset),
         .ena_i   (ena),
         .sync_i  (sync_all),
         .freq_i  (freq_q[c]),
         .pofs_i  (pofs_q[c]),
         .amp_i   (amp_q[c]),
         .mode_i  (mode_q[c]),
         .dout_o  (dout[c*DW +: DW]),
         .valid_o (chan_vld[c])
      );
   end

   assign valid = &chan_vld;

endmodule
